// File: rtl/tilt_decoder.sv
// rtl/tilt_decoder.sv - two-axis tilt classifier with windowed averaging, hysteresis and debounce

module tilt_decoder #(
  parameter int W        = 9,
  parameter int CENTER_X = 385,
  parameter int CENTER_Y = 80,
  parameter int DEADBAND = 4,
  parameter int HYST     = 2,
  parameter int AVG_LOG2 = 2,
  parameter int STABLE   = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         sample_valid,
  input  logic [W-1:0] accel_x,
  input  logic [W-1:0] accel_y,
  output logic         up,
  output logic         down,
  output logic         restx,
  output logic         right,
  output logic         left,
  output logic         resty,
  output logic         dir_change,
  output logic [W-1:0] avg_x,
  output logic [W-1:0] avg_y
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = W + AVG_LOG2;
  localparam int DW = W + 2;
  localparam int FW = $clog2(N + 1);
  localparam int CW = $clog2(STABLE + 1);

  // Thresholds in the signed difference domain
  localparam logic signed [DW-1:0] P_DB  = $signed(DW'(DEADBAND));
  localparam logic signed [DW-1:0] N_DB  = $signed(DW'(-DEADBAND));
  localparam logic signed [DW-1:0] P_RET = $signed(DW'(DEADBAND - HYST));
  localparam logic signed [DW-1:0] N_RET = $signed(DW'(-(DEADBAND - HYST)));

  typedef enum logic [1:0] {
    ST_REST = 2'd0,
    ST_POS  = 2'd1,
    ST_NEG  = 2'd2
  } tilt_t;

  // {pos, neg, rest} one-hot for the output pins
  function automatic logic [2:0] onehot(input tilt_t st);
    case (st)
      ST_POS:  return 3'b100;
      ST_NEG:  return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  logic [FW-1:0] r_fill;
  logic          r_dir;
  logic          w_full;

  // The sample that completes the window is the first one classified
  assign w_full = (r_fill >= FW'(N - 1));

  for (genvar a = 0; a < 2; a++) begin : g_axis
    localparam int CENTER = (a == 0) ? CENTER_X : CENTER_Y;
    localparam logic signed [DW-1:0] C_S = $signed(DW'(CENTER));

    logic [W-1:0]          w_in;
    logic [W-1:0]          r_buf [N];
    logic [SW-1:0]         r_sum;
    logic [SW-1:0]         w_sum_next;
    logic [W-1:0]          w_avg_next;
    logic [W-1:0]          r_avg;
    logic signed [DW-1:0]  w_diff;
    tilt_t                 r_state;
    tilt_t                 w_state_next;
    tilt_t                 r_cand;
    tilt_t                 w_cand_next;
    tilt_t                 w_target;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_next;
    logic [CW-1:0]         w_cnt_inc;
    logic [2:0]            r_oh;
    logic                  w_chg;

    assign w_in       = (a == 0) ? accel_x : accel_y;
    assign w_sum_next = r_sum + SW'(w_in) - SW'(r_buf[N-1]);
    assign w_avg_next = W'(w_sum_next >> AVG_LOG2);
    // Classification sees the average that includes the current sample
    assign w_diff     = $signed({2'b00, w_avg_next}) - C_S;
    assign w_chg      = (w_state_next != r_state);

    // Sample window, running sum and registered average
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < N; i++) r_buf[i] <= '0;
        r_sum <= '0;
        r_avg <= '0;
      end else if (sample_valid) begin
        for (int i = N - 1; i > 0; i--) r_buf[i] <= r_buf[i-1];
        r_buf[0] <= w_in;
        r_sum    <= w_sum_next;
        r_avg    <= w_avg_next;
      end
    end

    // Target state from the current committed state with hysteresis on return to rest
    always_comb begin
      w_target = r_state;
      case (r_state)
        ST_POS: begin
          if (w_diff < N_DB)        w_target = ST_NEG;
          else if (w_diff <= P_RET) w_target = ST_REST;
          else                      w_target = ST_POS;
        end
        ST_NEG: begin
          if (w_diff > P_DB)        w_target = ST_POS;
          else if (w_diff >= N_RET) w_target = ST_REST;
          else                      w_target = ST_NEG;
        end
        default: begin
          if (w_diff > P_DB)        w_target = ST_POS;
          else if (w_diff < N_DB)   w_target = ST_NEG;
          else                      w_target = ST_REST;
        end
      endcase
    end

    // Debounce: a differing target must repeat STABLE times before it is committed
    always_comb begin
      w_state_next = r_state;
      w_cand_next  = r_cand;
      w_cnt_next   = r_cnt;
      w_cnt_inc    = r_cnt;
      if (sample_valid && w_full) begin
        if (w_target == r_state) begin
          w_cnt_next = '0;
        end else begin
          if (w_target == r_cand) begin
            w_cnt_inc = r_cnt + 1'b1;
          end else begin
            w_cand_next = w_target;
            w_cnt_inc   = CW'(1);
          end
          if (w_cnt_inc == CW'(STABLE)) begin
            w_state_next = w_cand_next;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
      end
    end

    // Committed state, candidate, counter and one-hot output register
    always_ff @(posedge clock) begin
      if (reset) begin
        r_state <= ST_REST;
        r_cand  <= ST_REST;
        r_cnt   <= '0;
        r_oh    <= 3'b001;
      end else begin
        r_state <= w_state_next;
        r_cand  <= w_cand_next;
        r_cnt   <= w_cnt_next;
        r_oh    <= onehot(w_state_next);
      end
    end
  end

  // Shared fill counter and single change pulse covering both axes
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fill <= '0;
      r_dir  <= 1'b0;
    end else begin
      if (sample_valid && (r_fill != FW'(N))) r_fill <= r_fill + 1'b1;
      r_dir <= g_axis[0].w_chg | g_axis[1].w_chg;
    end
  end

  assign {up, down, restx}    = g_axis[0].r_oh;
  assign {right, left, resty} = g_axis[1].r_oh;
  assign dir_change           = r_dir;
  assign avg_x                = g_axis[0].r_avg;
  assign avg_y                = g_axis[1].r_avg;

endmodule

// File: tb/tb_tilt_decoder.sv
// tb/tb_tilt_decoder.sv - scoreboard bench for tilt_decoder at default parameters

module tb_tilt_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       sample_valid;
  logic [8:0] accel_x;
  logic [8:0] accel_y;
  logic       up, down, restx, right, left, resty, dir_change;
  logic [8:0] avg_x, avg_y;

  tilt_decoder dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid),
    .accel_x(accel_x), .accel_y(accel_y),
    .up(up), .down(down), .restx(restx),
    .right(right), .left(left), .resty(resty),
    .dir_change(dir_change), .avg_x(avg_x), .avg_y(avg_y)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [8:0] ax;
    logic [8:0] ay;
    logic [6:0] fl;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   dc_seen;
  bit   rest_seen;

  // reference model: 0 = rest, 1 = pos, 2 = neg
  int m_win[2][4];
  int m_avg[2];
  int m_st[2];
  int m_cand[2];
  int m_cnt[2];
  int m_fill;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int classify(input int st, input int d);
    case (st)
      1:       return (d < -4) ? 2 : ((d <= 2) ? 0 : 1);
      2:       return (d > 4) ? 1 : ((d >= -2) ? 0 : 2);
      default: return (d > 4) ? 1 : ((d < -4) ? 2 : 0);
    endcase
  endfunction

  function automatic exp_t snap(input bit dc);
    exp_t e;
    e.ax = 9'(m_avg[0]);
    e.ay = 9'(m_avg[1]);
    e.fl = {m_st[0] == 1, m_st[0] == 2, m_st[0] == 0,
            m_st[1] == 1, m_st[1] == 2, m_st[1] == 0, dc};
    return e;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      for (int i = 0; i < 4; i++) m_win[a][i] = 0;
      m_avg[a] = 0; m_st[a] = 0; m_cand[a] = 0; m_cnt[a] = 0;
    end
    m_fill = 0;
    exp_q.push_back(snap(1'b0));
  endtask

  task automatic model_sample(input int x, input int y);
    bit full;
    bit chg;
    int sum;
    int tgt;
    full = (m_fill + 1 >= 4);
    chg  = 1'b0;
    for (int a = 0; a < 2; a++) begin
      for (int i = 0; i < 3; i++) m_win[a][i] = m_win[a][i+1];
      m_win[a][3] = (a == 0) ? x : y;
      sum = 0;
      for (int i = 0; i < 4; i++) sum += m_win[a][i];
      m_avg[a] = sum / 4;
      if (full) begin
        tgt = classify(m_st[a], m_avg[a] - ((a == 0) ? 385 : 80));
        if (tgt == m_st[a]) begin
          m_cnt[a] = 0;
        end else begin
          if (tgt == m_cand[a]) m_cnt[a]++;
          else begin m_cand[a] = tgt; m_cnt[a] = 1; end
          if (m_cnt[a] == 3) begin
            m_st[a] = m_cand[a]; m_cnt[a] = 0; chg = 1'b1;
          end
        end
      end
    end
    if (m_fill < 4) m_fill++;
    exp_q.push_back(snap(chg));
  endtask

  task automatic compare_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_avg_x", avg_x, e.ax);
      check("sb_avg_y", avg_y, e.ay);
      check("sb_flags", {up, down, restx, right, left, resty, dir_change}, e.fl);
    end
    dc_seen   += dir_change;
    rest_seen |= restx;
  endtask

  task automatic cycle(input bit v, input int x, input int y);
    sample_valid = v;
    accel_x      = 9'(x);
    accel_y      = 9'(y);
    if (v) model_sample(x, y);
    else   exp_q.push_back(snap(1'b0));
    @(posedge clock); #1;
    compare_pop();
  endtask

  task automatic do_reset(input bit v, input int x);
    reset        = 1'b1;
    sample_valid = v;
    accel_x      = 9'(x);
    accel_y      = 9'd80;
    model_reset();
    @(posedge clock); #1;
    compare_pop();
    reset        = 1'b0;
    sample_valid = 1'b0;
  endtask

  int a19[4] = '{387, 390, 392, 395};
  int a20a[4] = '{393, 391, 389, 388};
  int a20b[3] = '{387, 387, 386};
  int a21[5] = '{388, 382, 376, 370, 370};
  int a23[3] = '{98, 197, 296};

  initial begin
    reset = 1'b1; sample_valid = 1'b0; accel_x = '0; accel_y = '0;
    #2;
    do_reset(1'b0, 0);
    check("rst_restx", restx, 1);
    check("rst_resty", resty, 1);
    check("rst_dir", dir_change, 0);
    check("rst_avg_x", avg_x, 0);

    // rest fill
    dc_seen = 0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 385, 80);
    check("fill_avg_x", avg_x, 385);
    check("fill_avg_y", avg_y, 80);
    check("fill_rest", {restx, resty}, 2'b11);
    check("fill_no_dc", dc_seen, 0);

    // tilt commit
    dc_seen = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 395, 80);
      check("tilt_avg", avg_x, a19[i]);
      if (i == 2) check("tilt_early_up", up, 0);
    end
    check("tilt_up", up, 1);
    check("tilt_restx", restx, 0);
    check("tilt_pulse_now", dir_change, 1);
    cycle(1'b0, 0, 80);
    check("tilt_pulse_end", dir_change, 0);
    check("tilt_pulses", dc_seen, 1);

    // hysteresis
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 388, 80);
      check("hyst_avg_a", avg_x, a20a[i]);
      check("hyst_up_held", up, 1);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 386, 80);
      check("hyst_avg_b", avg_x, a20b[i]);
      check("hyst_restx", restx, (i == 2) ? 1 : 0);
    end

    // back to a full 395 window with up committed
    for (int i = 0; i < 4; i++) cycle(1'b1, 395, 80);
    check("retilt_up", up, 1);
    check("retilt_avg", avg_x, 395);

    // reversal without passing through rest
    dc_seen = 0; rest_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 370, 80);
      check("rev_avg", avg_x, a21[i]);
      check("rev_down", down, (i == 4) ? 1 : 0);
    end
    check("rev_no_rest", rest_seen, 0);
    check("rev_pulses", dc_seen, 1);

    // gating: nothing moves without sample_valid
    dc_seen = 0;
    for (int i = 0; i < 100; i++) cycle(1'b0, $urandom_range(0, 511), (i % 2) ? 200 : 80);
    check("gate_avg_x", avg_x, 370);
    check("gate_avg_y", avg_y, 80);
    check("gate_down", down, 1);
    check("gate_no_dc", dc_seen, 0);

    // reset mid-operation with a partial stability count
    for (int i = 0; i < 6; i++) cycle(1'b1, 395, 80);
    check("mid_up", up, 1);
    cycle(1'b1, 300, 80);
    check("mid_partial_up", up, 1);
    do_reset(1'b1, 395);
    check("mid_rst_restx", restx, 1);
    check("mid_rst_up", up, 0);
    check("mid_rst_dir", dir_change, 0);
    check("mid_rst_avg", avg_x, 0);
    dc_seen = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 395, 60);
      check("refill_avg", avg_x, a23[i]);
      check("refill_no_up", up, 0);
    end

    // simultaneous x and y commit gives one pulse
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 395, 60);
      check("both_up", up, (i == 2) ? 1 : 0);
      check("both_left", left, (i == 2) ? 1 : 0);
    end
    cycle(1'b0, 0, 0);
    check("both_pulses", dc_seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tilt_decoder.md
TILT_DECODER -- requirements
Module: tilt_decoder

Interface
REQ-001 The block SHALL have the following parameters:
- W, 9: accelerometer axis sample width (unsigned).
- CENTER_X, 385: x-axis rest value.
- CENTER_Y, 80: y-axis rest value.
- DEADBAND, 4: magnitude of |avg-center| that must be exceeded to leave rest.
- HYST, 2: hysteresis; return to rest when |avg-center| <= DEADBAND-HYST.
- AVG_LOG2, 2: sliding-average window of 2^AVG_LOG2 samples.
- STABLE, 3: consecutive averaged samples required to commit a new state.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clock, in, 1: single system clock, all logic on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- sample_valid, in, 1: accel_x/accel_y hold a new sample this cycle.
- accel_x, in, W: raw x-axis sample.
- accel_y, in, W: raw y-axis sample.
- up / down / restx, out, 1 each: committed x state (POS / NEG / REST).
- right / left / resty, out, 1 each: committed y state (POS / NEG / REST).
- dir_change, out, 1: one-cycle pulse when any committed state changes.
- avg_x / avg_y, out, W: current windowed averages.

REQ-003 Constraints: DEADBAND >= HYST; STABLE >= 1; AVG_LOG2 >= 0.

Function
REQ-004 Sampling:
- Sampling SHALL occur only in cycles with sample_valid=1.
- Inputs SHALL be ignored when sample_valid=0.

REQ-005 Windowed sum:
- Each axis SHALL keep a 2^AVG_LOG2-deep sample buffer and a running sum of width W+AVG_LOG2.
- On each valid sample: sum <= sum + new - oldest, then the buffer shifts.

REQ-006 Averages:
- avg = sum >> AVG_LOG2 (truncating).
- avg_x/avg_y SHALL update one clock after the sample_valid cycle.

REQ-007 Fill:
- A fill counter SHALL count valid samples up to 2^AVG_LOG2.
- Until full, no classification SHALL occur, and committed states and counters SHALL hold.

REQ-008 Per-axis difference:
- diff = avg - CENTER, computed signed in W+2 bits.
- No saturation is required.

REQ-009 Target classification, evaluated per axis on every valid sample once full:
- From REST: target = POS if diff > DEADBAND; NEG if diff < -DEADBAND; else REST.
- From POS: target = NEG if diff < -DEADBAND; REST if diff <= DEADBAND-HYST; else POS.
- From NEG: target = POS if diff > DEADBAND; REST if diff >= -(DEADBAND-HYST); else NEG.

REQ-010 Stability counter:
- Target equals committed state: counter SHALL clear to 0.
- Target differs and equals the previous candidate: counter increments.
- Otherwise: candidate <= target and counter <= 1.

REQ-011 Commit:
- When the counter reaches STABLE, committed state <= candidate and the counter clears.
- Outputs SHALL change one clock after the completing sample_valid cycle.

REQ-012 Outputs:
- {up, down, restx} SHALL be one-hot from the x committed state.
- {right, left, resty} SHALL be one-hot from the y committed state.
- All outputs SHALL be registered.

REQ-013 dir_change:
- SHALL be high for exactly the one cycle in which any committed state changes.
- A simultaneous x and y change SHALL produce a single pulse.

REQ-014 POS<->NEG reversal SHALL be allowed without committing REST in between.

Reset
REQ-015 On reset=1 at a clock edge, the block SHALL set:
- restx=resty=1;
- up/down/left/right=0;
- dir_change=0;
- avg_x/avg_y=0;
- sums, buffers, fill counter, stability counters and candidates cleared.

REQ-016 Reset SHALL take precedence over a simultaneous sample_valid.

REQ-017 After reset, a full refill of 2^AVG_LOG2 samples SHALL be required before any classification.

Verification (default parameters)
REQ-018 Rest fill:
- Stimulus: reset, then 4 samples of x=385, y=80.
- Response: restx=resty=1, dir_change never asserted, avg_x=385, avg_y=80.

REQ-019 Tilt commit:
- Stimulus: after rest fill, x=395 samples.
- Response: averages 387, 390, 392, 395; up=1 one clock after the 4th sample; one dir_change pulse; restx=0.

REQ-020 Hysteresis:
- Stimulus: from the committed up state, 4 samples of x=388, then x=386 samples.
- Response: up held throughout the 388 samples (averages 393..388); restx=1 after the 3rd 386 sample (averages 387, 387, 386).

REQ-021 Reversal:
- Stimulus: from a full 395 window with up committed, x=370 samples.
- Response: averages 388, 382, 376, 370, 370; down=1 after the 5th sample; restx never asserted; exactly one dir_change pulse.

REQ-022 Gating:
- Stimulus: accel_y toggling 80/200 with sample_valid=0 for 100 cycles.
- Response: all outputs and averages unchanged.

REQ-023 Reset mid-operation:
- Stimulus: with up committed and a partial stability count, assert reset together with sample_valid=1.
- Response: next cycle restx=1, up=0, dir_change=0; 3 further x=395 samples do not commit up (fill incomplete).
